// File: rtl/uart_frame_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_frame_feeder
// Purpose  : Drains an upstream byte FIFO into UART frames of the form
//            HEADER, FRAME_LEN data bytes, XOR checksum of the data bytes.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_feeder #(
    parameter int         FRAME_LEN = 4,
    parameter logic [7:0] HEADER    = 8'hAA
) (
    input  logic       clk_50m,
    input  logic       reset,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_q,
    output logic       fifo_rdreq,
    input  logic       tx_busy,
    output logic       tx_wr_en,
    output logic [7:0] tx_data,
    output logic       frame_busy,
    output logic [7:0] frame_count
);

    localparam logic [7:0] C_FRAME_LEN = 8'(FRAME_LEN);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        RD_REQ    = 3'd2,
        RD_WAIT   = 3'd3,
        SEND_DATA = 3'd4,
        SEND_CHK  = 3'd5,
        WAIT_TX   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SENT_HDR  = 2'd0,
        SENT_DATA = 2'd1,
        SENT_CHK  = 2'd2
    } sent_t;

    state_t     state_q;
    sent_t      sent_q;
    logic       guard_q;
    logic [7:0] chk_q;
    logic [7:0] cnt_q;
    logic [7:0] data_q;
    logic [7:0] tx_last_q;
    logic       frame_busy_q;
    logic [7:0] frame_count_q;

    logic       w_send_state;
    logic [7:0] tx_byte_d;

    assign w_send_state = (state_q == SEND_HDR) || (state_q == SEND_DATA) ||
                          (state_q == SEND_CHK);

    always_comb begin
        tx_byte_d = HEADER;
        if (state_q == SEND_DATA) begin
            tx_byte_d = data_q;
        end else if (state_q == SEND_CHK) begin
            tx_byte_d = chk_q;
        end
    end

    // The strobe is qualified by tx_busy in the same cycle so it can never
    // coincide with a busy transmitter; tx_data holds the last sent byte
    // between strobes.
    assign tx_wr_en    = w_send_state && !tx_busy;
    assign tx_data     = tx_wr_en ? tx_byte_d : tx_last_q;
    assign fifo_rdreq  = (state_q == RD_REQ) && !fifo_empty;
    assign frame_busy  = frame_busy_q;
    assign frame_count = frame_count_q;

    always_ff @(posedge clk_50m or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            sent_q        <= SENT_HDR;
            guard_q       <= 1'b0;
            chk_q         <= 8'd0;
            cnt_q         <= 8'd0;
            data_q        <= 8'd0;
            tx_last_q     <= 8'd0;
            frame_busy_q  <= 1'b0;
            frame_count_q <= 8'd0;
        end else begin
            if (tx_wr_en) begin
                tx_last_q <= tx_byte_d;
            end
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q      <= SEND_HDR;
                        chk_q        <= 8'd0;
                        cnt_q        <= 8'd0;
                        frame_busy_q <= 1'b1;
                    end
                end
                SEND_HDR: begin
                    if (!tx_busy) begin
                        sent_q  <= SENT_HDR;
                        guard_q <= 1'b1;
                        state_q <= WAIT_TX;
                    end
                end
                SEND_DATA: begin
                    if (!tx_busy) begin
                        sent_q  <= SENT_DATA;
                        guard_q <= 1'b1;
                        state_q <= WAIT_TX;
                    end
                end
                SEND_CHK: begin
                    if (!tx_busy) begin
                        sent_q  <= SENT_CHK;
                        guard_q <= 1'b1;
                        state_q <= WAIT_TX;
                    end
                end
                RD_REQ: begin
                    if (!fifo_empty) begin
                        state_q <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    data_q  <= fifo_q;
                    chk_q   <= chk_q ^ fifo_q;
                    cnt_q   <= cnt_q + 8'd1;
                    state_q <= SEND_DATA;
                end
                WAIT_TX: begin
                    // The transmitter may not raise busy until a cycle after
                    // the load strobe, so the first WAIT_TX cycle is skipped.
                    if (guard_q) begin
                        guard_q <= 1'b0;
                    end else if (!tx_busy) begin
                        case (sent_q)
                            SENT_HDR:  state_q <= RD_REQ;
                            SENT_DATA: state_q <= (cnt_q < C_FRAME_LEN) ? RD_REQ : SEND_CHK;
                            SENT_CHK: begin
                                state_q       <= IDLE;
                                frame_busy_q  <= 1'b0;
                                frame_count_q <= frame_count_q + 8'd1;
                            end
                            default:   state_q <= IDLE;
                        endcase
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_feeder.md
UART_FRAME_FEEDER -- requirements
Module: uart_frame_feeder

Interface
REQ-001 Parameter FRAME_LEN, default 4: data bytes per frame, legal range 1..255.
REQ-002 Parameter HEADER, default 8'hAA: start-of-frame byte.
REQ-003 clk_50m  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 fifo_q  input  8  upstream FIFO read data, normal (non-show-ahead) mode, valid the cycle after fifo_rdreq.
REQ-007 fifo_rdreq  output  1  FIFO read strobe.
REQ-008 tx_busy  input  1  UART transmitter busy flag.
REQ-009 tx_wr_en  output  1  transmitter load strobe.
REQ-010 tx_data  output  8  byte presented to the transmitter.
REQ-011 frame_busy  output  1  high from frame start until the checksum byte is fully sent.
REQ-012 frame_count  output  8  completed-frame counter.

Function
REQ-013 The block SHALL drain the FIFO into frames: HEADER, then FRAME_LEN data bytes in FIFO order, then CHK = XOR of the FRAME_LEN data bytes; HEADER is excluded from CHK.
REQ-014 FSM states SHALL be IDLE, SEND_HDR, RD_REQ, RD_WAIT, SEND_DATA, SEND_CHK, WAIT_TX.
REQ-015 IDLE -> SEND_HDR when fifo_empty=0; otherwise stay in IDLE. Entering SEND_HDR clears CHK and the byte counter, and sets frame_busy.
REQ-016 SEND_* with tx_busy=1: hold the state. SEND_* with tx_busy=0: drive tx_data and pulse tx_wr_en, then go to WAIT_TX.
REQ-017 tx_wr_en SHALL be high for exactly one cycle per byte, and never in a cycle where tx_busy=1.
REQ-018 tx_data SHALL be stable from the tx_wr_en cycle until the next tx_wr_en.
REQ-019 WAIT_TX SHALL ignore tx_busy in its first cycle (guard cycle). After that it waits for tx_busy=0, then returns:
- after HEADER -> RD_REQ
- after a data byte -> RD_REQ if byte counter < FRAME_LEN, else SEND_CHK
- after CHK -> IDLE
REQ-020 RD_REQ: fifo_rdreq = (state==RD_REQ && fifo_empty==0), combinational, one cycle. On a read go to RD_WAIT; if the FIFO is empty, stall in RD_REQ indefinitely, holding frame_busy high.
REQ-021 fifo_rdreq SHALL never assert while fifo_empty=1, and SHALL pulse at most once per data byte.
REQ-022 RD_WAIT: latch fifo_q into the data register, XOR it into CHK, increment the byte counter, then go to SEND_DATA.
REQ-023 Latency from IDLE with fifo_empty=0 and tx_busy=0: HEADER tx_wr_en occurs no later than 2 cycles after fifo_empty falls.
REQ-024 On the cycle the CHK byte leaves WAIT_TX:
- frame_count increments modulo 256 (255 -> 0)
- frame_busy falls
- a back-to-back frame may start on the next cycle.
REQ-025 The byte counter SHALL be 8 bits, counting 1..FRAME_LEN, with no wrap within a frame.

Reset
REQ-026 On reset=1, immediately and independent of clk_50m:
- state=IDLE
- fifo_rdreq=0, tx_wr_en=0, tx_data=0, frame_busy=0, frame_count=0
- CHK=0, byte counter=0, data register=0
REQ-027 Reset mid-frame SHALL abandon the partial frame; no data is replayed. The first frame after release starts with HEADER and a fresh CHK.
REQ-028 While reset=1, fifo_rdreq and tx_wr_en SHALL remain 0 regardless of inputs.

Verification
REQ-029 FIFO preloaded 01,02,03,04; transmitter model busy 10 cycles per byte -> tx stream AA,01,02,03,04,04; exactly 4 fifo_rdreq pulses; frame_count=1; frame_busy low afterward.
REQ-030 FIFO holds 2 bytes, empty for 100 cycles, then 2 more bytes arrive -> FSM stalls in RD_REQ with zero rdreq while empty; frame completes correctly; frame_busy high throughout.
REQ-031 tx_busy forced high for 50 cycles while FIFO is non-empty -> no tx_wr_en during those cycles; HEADER tx_wr_en within 1 cycle of tx_busy falling.
REQ-032 Data FF,FF,00,0F -> CHK byte 0F; data 00,00,00,00 -> CHK byte 00.
REQ-033 Reset pulsed after the second data byte is sent -> all outputs 0 asynchronously; the next frame sends AA plus the remaining FIFO bytes with a new CHK.
REQ-034 257 consecutive frames -> frame_count reads 00 after frame 256 and 01 after frame 257; no gaps or duplicate bytes in the tx stream.
